// File: rtl/free_list.sv
// Circular free list of physical register numbers between rename and retire.
// Supports multi-wide allocate and release, and single-cycle recovery on flush.

`ifndef SYNTHESIS
module free_list_chk #(
   parameter int PTR      = 6,
   parameter int FL_DEPTH = 32
) (
   input logic           clk,
   input logic           rst,
   input logic [PTR-1:0] cnt,
   input logic [PTR-1:0] rel_cnt
);

   // Returning more pregs than there are empty slots would overwrite free entries.
   always @(posedge clk) begin
      if (rst) begin
         assert ({1'b0, cnt} + {1'b0, rel_cnt} <= (PTR+1)'(FL_DEPTH))
            else $error("free_list overflow: free %0d plus released %0d exceeds capacity",
                        cnt, rel_cnt);
      end
   end

endmodule
`endif

module free_list #(
   parameter int PREG       = 6,
   parameter int AREG       = 5,
   parameter int DECODE_NUM = 4,
   parameter int RETIRE_NUM = 4,
   parameter int FL_DEPTH   = (1 << PREG) - (1 << AREG)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [2:0]                           alloc_num,
   output logic                                 alloc_ok,
   output logic [DECODE_NUM-1:0][PREG-1:0]      alloc_preg,
   input  logic [RETIRE_NUM-1:0]                rel_v,
   input  logic [RETIRE_NUM-1:0][PREG-1:0]      rel_preg,
   input  logic                                 flush,
   output logic [PREG-1:0]                      free_cnt
);

   localparam int IDX = $clog2(FL_DEPTH);
   localparam int PTR = IDX + 1;

   logic [PREG-1:0]                 entry_r [FL_DEPTH];
   logic [PTR-1:0]                  head_r;
   logic [PTR-1:0]                  tail_r;
   logic [PTR-1:0]                  cnt_s;
   logic [PTR-1:0]                  tail_nxt_s;
   logic [PTR-1:0]                  rel_cnt_s;
   logic [RETIRE_NUM-1:0][PTR-1:0]  rel_off_s;

   // Free count and allocation view, taken from registered state only.
   always_comb begin
      cnt_s      = tail_r - head_r;
      alloc_ok   = (alloc_num <= 3'(DECODE_NUM)) && (cnt_s >= PTR'(alloc_num));
      alloc_preg = '0;
      for (int k = 0; k < DECODE_NUM; k++) begin
         alloc_preg[k] = entry_r[IDX'(head_r + PTR'(k))];
      end
   end

   // Compact valid release slots: each gets the count of valid slots below it.
   always_comb begin
      rel_off_s = '0;
      rel_cnt_s = '0;
      for (int i = 0; i < RETIRE_NUM; i++) begin
         rel_off_s[i] = rel_cnt_s;
         if (rel_v[i]) begin
            rel_cnt_s = rel_cnt_s + PTR'(1);
         end else begin
            rel_cnt_s = rel_cnt_s;
         end
      end
      tail_nxt_s = tail_r + rel_cnt_s;
   end

   // Storage: initial contents are the pregs not held by the architectural map.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            entry_r[i] <= PREG'((1 << AREG) + i);
         end
      end else begin
         for (int i = 0; i < RETIRE_NUM; i++) begin
            if (rel_v[i]) begin
               entry_r[IDX'(tail_r + rel_off_s[i])] <= rel_preg[i];
            end
         end
      end
   end

   // Flush rewinds head one full lap behind the new tail, re-exposing the
   // in-flight pregs that still sit physically behind the old head.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_r <= '0;
         tail_r <= PTR'(FL_DEPTH);
      end else begin
         tail_r <= tail_nxt_s;
         if (flush) begin
            head_r <= {~tail_nxt_s[IDX], tail_nxt_s[IDX-1:0]};
         end else if (alloc_ok) begin
            head_r <= head_r + PTR'(alloc_num);
         end
      end
   end

   assign free_cnt = PREG'(cnt_s);

`ifndef SYNTHESIS
   free_list_chk #(
      .PTR      (PTR),
      .FL_DEPTH (FL_DEPTH)
   ) u_chk (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt_s),
      .rel_cnt (rel_cnt_s)
   );
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed and random-traffic bench for free_list with hand-computed
// expectations and a queue-based model of the free pool.

module tb_free_list;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [2:0]       alloc_num;
   logic             alloc_ok;
   logic [3:0][5:0]  alloc_preg;
   logic [3:0]       rel_v;
   logic [3:0][5:0]  rel_preg;
   logic             flush;
   logic [5:0]       free_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   free_list dut (
      .clk        (clk),
      .rst        (rst),
      .alloc_num  (alloc_num),
      .alloc_ok   (alloc_ok),
      .alloc_preg (alloc_preg),
      .rel_v      (rel_v),
      .rel_preg   (rel_preg),
      .flush      (flush),
      .free_cnt   (free_cnt)
   );

   task automatic idle();
      alloc_num = 3'd0;
      rel_v     = 4'd0;
      rel_preg  = '0;
      flush     = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (free_cnt !== 6'd32) begin
         errors++; $display("FAIL reset_free_cnt got %0d exp 32", free_cnt);
      end
      checks++;
      if (alloc_ok !== 1'b1) begin
         errors++; $display("FAIL reset_alloc_ok got %0b exp 1", alloc_ok);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (alloc_preg[k] !== 6'(32 + k)) begin
            errors++; $display("FAIL reset_preg%0d got %0d exp %0d", k, alloc_preg[k], 32 + k);
         end
      end
   endtask

   task automatic test_alloc();
      alloc_num = 3'd4;
      #1;
      checks++;
      if (alloc_ok !== 1'b1) begin
         errors++; $display("FAIL alloc4_ok got %0b exp 1", alloc_ok);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (alloc_preg[k] !== 6'(32 + k)) begin
            errors++; $display("FAIL alloc4_preg%0d got %0d exp %0d", k, alloc_preg[k], 32 + k);
         end
      end
      tick();
      alloc_num = 3'd0;
      #1;
      checks++;
      if (free_cnt !== 6'd28) begin
         errors++; $display("FAIL alloc4_cnt got %0d exp 28", free_cnt);
      end
      checks++;
      if (alloc_preg[0] !== 6'd36) begin
         errors++; $display("FAIL alloc4_next got %0d exp 36", alloc_preg[0]);
      end
      checks++;
      if (alloc_ok !== 1'b1) begin
         errors++; $display("FAIL alloc0_ok got %0b exp 1", alloc_ok);
      end
      alloc_num = 3'd5;
      #1;
      checks++;
      if (alloc_ok !== 1'b0) begin
         errors++; $display("FAIL alloc5_ok got %0b exp 0", alloc_ok);
      end
      alloc_num = 3'd7;
      tick();
      checks++;
      if (free_cnt !== 6'd28) begin
         errors++; $display("FAIL alloc7_hold got %0d exp 28", free_cnt);
      end
   endtask

   task automatic test_empty();
      alloc_num = 3'd4;
      repeat (7) tick();
      alloc_num = 3'd0;
      #1;
      checks++;
      if (free_cnt !== 6'd0) begin
         errors++; $display("FAIL empty_cnt got %0d exp 0", free_cnt);
      end
      alloc_num = 3'd1;
      #1;
      checks++;
      if (alloc_ok !== 1'b0) begin
         errors++; $display("FAIL empty_ok got %0b exp 0", alloc_ok);
      end
      tick();
      checks++;
      if (free_cnt !== 6'd0) begin
         errors++; $display("FAIL empty_hold_cnt got %0d exp 0", free_cnt);
      end
      checks++;
      if (alloc_preg[0] !== 6'd32) begin
         errors++; $display("FAIL empty_hold_head got %0d exp 32", alloc_preg[0]);
      end
      alloc_num   = 3'd0;
      rel_v       = 4'b0101;
      rel_preg[0] = 6'd5;
      rel_preg[1] = 6'd33;
      rel_preg[2] = 6'd9;
      rel_preg[3] = 6'd40;
      tick();
      idle();
      #1;
      checks++;
      if (free_cnt !== 6'd2) begin
         errors++; $display("FAIL sparse_rel_cnt got %0d exp 2", free_cnt);
      end
      checks++;
      if (alloc_preg[0] !== 6'd5) begin
         errors++; $display("FAIL sparse_rel_p0 got %0d exp 5", alloc_preg[0]);
      end
      checks++;
      if (alloc_preg[1] !== 6'd9) begin
         errors++; $display("FAIL sparse_rel_p1 got %0d exp 9", alloc_preg[1]);
      end
   endtask

   task automatic test_no_bypass();
      logic [5:0] exp_p [4];
      exp_p = '{6'd5, 6'd9, 6'd1, 6'd2};
      alloc_num = 3'd3;
      rel_v     = 4'b1111;
      for (int i = 0; i < 4; i++) rel_preg[i] = 6'(i + 1);
      #1;
      checks++;
      if (alloc_ok !== 1'b0) begin
         errors++; $display("FAIL nobypass_ok got %0b exp 0", alloc_ok);
      end
      checks++;
      if (free_cnt !== 6'd2) begin
         errors++; $display("FAIL nobypass_cnt got %0d exp 2", free_cnt);
      end
      tick();
      rel_v = 4'd0;
      #1;
      checks++;
      if (free_cnt !== 6'd6) begin
         errors++; $display("FAIL after_rel_cnt got %0d exp 6", free_cnt);
      end
      checks++;
      if (alloc_ok !== 1'b1) begin
         errors++; $display("FAIL after_rel_ok got %0b exp 1", alloc_ok);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (alloc_preg[k] !== exp_p[k]) begin
            errors++; $display("FAIL after_rel_p%0d got %0d exp %0d", k, alloc_preg[k], exp_p[k]);
         end
      end
   endtask

   task automatic test_flush();
      logic [5:0] exp_p [4];
      exp_p = '{6'd62, 6'd63, 6'd7, 6'd8};
      do_reset();
      alloc_num = 3'd4;
      tick();
      tick();
      alloc_num = 3'd2;
      tick();
      alloc_num = 3'd0;
      #1;
      checks++;
      if (free_cnt !== 6'd22) begin
         errors++; $display("FAIL preflush_cnt got %0d exp 22", free_cnt);
      end
      flush       = 1'b1;
      alloc_num   = 3'd4;
      rel_v       = 4'b0011;
      rel_preg[0] = 6'd7;
      rel_preg[1] = 6'd8;
      rel_preg[2] = 6'd50;
      rel_preg[3] = 6'd51;
      #1;
      checks++;
      if (alloc_ok !== 1'b1) begin
         errors++; $display("FAIL flush_cycle_ok got %0b exp 1", alloc_ok);
      end
      tick();
      idle();
      #1;
      checks++;
      if (free_cnt !== 6'd32) begin
         errors++; $display("FAIL flush_cnt got %0d exp 32", free_cnt);
      end
      checks++;
      if (alloc_preg[0] !== 6'd34) begin
         errors++; $display("FAIL flush_head_p0 got %0d exp 34", alloc_preg[0]);
      end
      checks++;
      if (alloc_preg[1] !== 6'd35) begin
         errors++; $display("FAIL flush_head_p1 got %0d exp 35", alloc_preg[1]);
      end
      alloc_num = 3'd4;
      repeat (7) tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (alloc_preg[k] !== exp_p[k]) begin
            errors++; $display("FAIL flush_tail_p%0d got %0d exp %0d", k, alloc_preg[k], exp_p[k]);
         end
      end
      tick();
      alloc_num = 3'd0;
      #1;
      checks++;
      if (free_cnt !== 6'd0) begin
         errors++; $display("FAIL flush_drain_cnt got %0d exp 0", free_cnt);
      end
   endtask

   task automatic test_random();
      logic [5:0] fq [$];
      logic [5:0] held [$];
      bit   [63:0] in_list;
      logic [5:0] p;
      logic [3:0] rv;
      int   an;
      int   lim;
      bit   exp_ok;
      do_reset();
      fq.delete();
      held.delete();
      in_list = '0;
      for (int i = 0; i < 32; i++) begin
         fq.push_back(6'(32 + i));
         held.push_back(6'(i));
         in_list[32 + i] = 1'b1;
      end
      for (int cyc = 0; cyc < 200; cyc++) begin
         an  = $urandom_range(0, 4);
         rv  = 4'($urandom_range(0, 15));
         lim = 32 - fq.size();
         for (int i = 3; i >= 0; i--) begin
            if ($countones(rv) > lim) rv[i] = 1'b0;
         end
         alloc_num = 3'(an);
         rel_v     = rv;
         for (int i = 0; i < 4; i++) begin
            if (rv[i]) rel_preg[i] = held.pop_front();
            else       rel_preg[i] = 6'($urandom_range(0, 63));
         end
         #1;
         exp_ok = (an <= fq.size());
         checks++;
         if (free_cnt !== 6'(fq.size())) begin
            errors++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", cyc, free_cnt, fq.size());
         end
         checks++;
         if (alloc_ok !== exp_ok) begin
            errors++; $display("FAIL rand_ok cyc %0d got %0b exp %0b", cyc, alloc_ok, exp_ok);
         end
         if (exp_ok) begin
            for (int k = 0; k < an; k++) begin
               checks++;
               if (alloc_preg[k] !== fq[k]) begin
                  errors++; $display("FAIL rand_preg cyc %0d slot %0d got %0d exp %0d", cyc, k, alloc_preg[k], fq[k]);
               end
               checks++;
               if (in_list[alloc_preg[k]] !== 1'b1) begin
                  errors++; $display("FAIL rand_dup cyc %0d slot %0d preg %0d not free", cyc, k, alloc_preg[k]);
               end
            end
            for (int k = 0; k < an; k++) begin
               p = fq.pop_front();
               in_list[p] = 1'b0;
               held.push_back(p);
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (rv[i]) begin
               fq.push_back(rel_preg[i]);
               in_list[rel_preg[i]] = 1'b1;
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      alloc_num = 3'd4;
      tick();
      tick();
      tick();
      #1;
      checks++;
      if (free_cnt !== 6'd20) begin
         errors++; $display("FAIL pre_areset_cnt got %0d exp 20", free_cnt);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (free_cnt !== 6'd32) begin
         errors++; $display("FAIL areset_cnt got %0d exp 32", free_cnt);
      end
      checks++;
      if (alloc_preg[0] !== 6'd32) begin
         errors++; $display("FAIL areset_p0 got %0d exp 32", alloc_preg[0]);
      end
      checks++;
      if (alloc_ok !== 1'b1) begin
         errors++; $display("FAIL areset_ok got %0b exp 1", alloc_ok);
      end
      idle();
      #2;
      rst = 1'b1;
   endtask

   initial begin
      idle();
      test_reset();
      test_alloc();
      test_empty();
      test_no_bypass();
      test_flush();
      test_random();
      test_async_reset();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
